// File: rtl/seq_magnitude_cmp.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per cycle, early exit on
// the first differing chunk, one-hot gt/lt/eq result with a start/busy/done handshake.
module seq_magnitude_cmp #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NCHUNK = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int PW     = NCHUNK * DIGIT;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] x_q, x_d, y_q, y_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

    logic [WIDTH-1:0] x_adj_s, y_adj_s;
    logic [PW-1:0]    x_ext_s, y_ext_s;
    logic [DIGIT-1:0] xc_s, yc_s;

    // Operand conditioning: offset-binary for signed mode, zero padding at the LSB end
    always_comb begin
        x_adj_s              = x;
        y_adj_s              = y;
        x_adj_s[WIDTH-1]     = x[WIDTH-1] ^ signed_mode;
        y_adj_s[WIDTH-1]     = y[WIDTH-1] ^ signed_mode;
        x_ext_s              = '0;
        y_ext_s              = '0;
        x_ext_s[PW-1 -: WIDTH] = x_adj_s;
        y_ext_s[PW-1 -: WIDTH] = y_adj_s;
        xc_s                 = x_q[idx_q*DIGIT +: DIGIT];
        yc_s                 = y_q[idx_q*DIGIT +: DIGIT];
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = x_ext_s;
                    y_d     = y_ext_s;
                    idx_d   = IW'(NCHUNK - 1);
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (xc_s > yc_s) begin
                    {gt_d, lt_d, eq_d} = 3'b100;
                    state_d            = ST_DONE;
                end else if (xc_s < yc_s) begin
                    {gt_d, lt_d, eq_d} = 3'b010;
                    state_d            = ST_DONE;
                end else if (idx_q == '0) begin
                    {gt_d, lt_d, eq_d} = 3'b001;
                    state_d            = ST_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_seq_magnitude_cmp.sv
// Directed bench for seq_magnitude_cmp: one DIGIT=1 and one DIGIT=4 instance, WIDTH=6.
module tb_seq_magnitude_cmp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic [5:0] x = 6'd0, y = 6'd0;
    logic       sm = 1'b0;
    logic       busy1, done1, gt1, lt1, eq1;
    logic       busy4, done4, gt4, lt4, eq4;
    logic       sel = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       busy_m, done_m;
    logic [2:0] res_m;

    always #5 clk = ~clk;

    seq_magnitude_cmp #(.WIDTH(6), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .x(x), .y(y), .signed_mode(sm),
        .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1)
    );

    seq_magnitude_cmp #(.WIDTH(6), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x), .y(y), .signed_mode(sm),
        .busy(busy4), .done(done4), .gt(gt4), .lt(lt4), .eq(eq4)
    );

    assign busy_m = sel ? busy4 : busy1;
    assign done_m = sel ? done4 : done1;
    assign res_m  = sel ? {gt4, lt4, eq4} : {gt1, lt1, eq1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One compare transaction; lat = cycle (after accepting edge) in which done is high.
    task automatic run(input string tag, input bit s, input logic [5:0] a, input logic [5:0] b,
                       input logic smode, input int lat, input logic [2:0] exp_res,
                       input logic [2:0] hold, input bit restart);
        int n;
        sel = s;
        @(negedge clk);
        x = a; y = b; sm = smode;
        if (s) start4 = 1'b1; else start1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start1 = 1'b0; start4 = 1'b0;
                x = ~a; y = ~b; sm = ~smode;
            end
            if (restart && n == 2) begin
                if (s) start4 = 1'b1; else start1 = 1'b1;
                x = 6'b111111; y = 6'b000000;
            end
            if (restart && n == 3) begin
                start1 = 1'b0; start4 = 1'b0;
            end
            if (!done_m) begin
                check({tag, "_busy"}, busy_m, 1);
                check({tag, "_hold"}, res_m, hold);
            end
        end while (!done_m && n < 20);
        start1 = 1'b0; start4 = 1'b0;
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, res_m, exp_res);
        check({tag, "_busy_done"}, busy_m, 1);
        @(negedge clk);
        check({tag, "_done_fall"}, done_m, 0);
        check({tag, "_idle"}, busy_m, 0);
        check({tag, "_res_keep"}, res_m, exp_res);
    endtask

    initial begin
        int n;
        #12;
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_res1", {gt1, lt1, eq1}, 3'b000);
        check("rst_res4", {busy4, done4, gt4, lt4, eq4}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;

        run("u_gt",    1'b0, 6'b100000, 6'b011111, 1'b0, 2, 3'b100, 3'b000, 1'b0);
        run("s_lt",    1'b0, 6'b100000, 6'b011111, 1'b1, 2, 3'b010, 3'b100, 1'b0);
        run("eq42",    1'b0, 6'd42,     6'd42,     1'b0, 7, 3'b001, 3'b010, 1'b0);
        run("lsb_gt",  1'b0, 6'd1,      6'd0,      1'b0, 7, 3'b100, 3'b001, 1'b0);
        run("pad_lt",  1'b1, 6'b000010, 6'b000011, 1'b0, 3, 3'b010, 3'b000, 1'b0);
        run("d4_gt",   1'b1, 6'b110000, 6'b010000, 1'b0, 2, 3'b100, 3'b010, 1'b0);
        run("d4_seq",  1'b1, 6'd7,      6'd7,      1'b0, 3, 3'b001, 3'b100, 1'b0);
        run("restart", 1'b0, 6'd4,      6'd6,      1'b0, 6, 3'b010, 3'b100, 1'b1);

        // Abort mid-SCAN with an asynchronous reset
        sel = 1'b0;
        @(negedge clk);
        x = 6'd42; y = 6'd42; sm = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("pre_abort_busy", busy1, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy1, 0);
        check("abort_res", {gt1, lt1, eq1}, 3'b000);
        check("abort_done", done1, 0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done1) n++;
        end
        check("abort_no_done", n, 0);
        rst = 1'b0;

        run("post_rst", 1'b0, 6'd5, 6'd9, 1'b0, 4, 3'b010, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_cmp.md
Name: seq_magnitude_cmp

Overview:
- Parametrised, multi-cycle magnitude comparator for the mini-ALU compare path.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and terminates early at the first differing chunk.
- Reports a one-hot result (gt / lt / eq) in unsigned or two's-complement signed mode.
- Uses a start/busy/done handshake toward the ALU control sequencer.

Parameters:
- WIDTH, 6, operand width in bits; must be >= 2.
- DIGIT, 1, bits compared per cycle; 1 <= DIGIT <= WIDTH.
- NCHUNK (localparam), ceil(WIDTH/DIGIT), worst-case number of compare cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  first operand; captured on the accepting edge.
- y  input  WIDTH  second operand; captured on the accepting edge.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with the operands.
- busy  output  1  high while in SCAN or DONE.
- done  output  1  one-cycle pulse; result valid.
- gt  output  1  x > y.
- lt  output  1  x < y.
- eq  output  1  x == y.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, done, gt, lt and eq all go to 0.
  - Operand registers and chunk index are cleared.
  - Reset asserted mid-SCAN aborts the comparison; no done pulse is issued.
- State machine: IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - busy=0.
  - start=1 at a rising edge captures x, y and signed_mode, sets chunk index to NCHUNK-1 (top chunk) and moves to SCAN.
- Signed mode: at capture, invert bit WIDTH-1 of both stored operands (offset-binary). The same unsigned chunk compare then yields the signed result.
- Padding: if WIDTH is not a multiple of DIGIT, the lowest chunk is zero-extended at its LSB end on both operands. Padding bits never create a difference.
- SCAN, one chunk per cycle:
  - xc > yc: set gt=1, lt=0, eq=0, go to DONE.
  - xc < yc: set lt=1, gt=0, eq=0, go to DONE.
  - Chunks equal and index == 0: set eq=1, gt=0, lt=0, go to DONE.
  - Otherwise: decrement index and stay in SCAN.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Unconditionally returns to IDLE at the next edge.
  - start is ignored in this cycle.
- Latency:
  - If the first differing chunk is chunk k, counted from the top (k=1 is the MSB chunk), done is high in the (k+1)-th cycle after the accepting edge.
  - Equal operands take NCHUNK+1 cycles.
  - A new start can be accepted at the first edge after done falls.
- Result hold:
  - gt/lt/eq are registered and change only on entry to DONE.
  - They hold their value through IDLE and the next SCAN until the next DONE.
  - Exactly one of gt/lt/eq is 1 after the first completed compare; all are 0 before it.
- start while busy (SCAN or DONE) is ignored. Input changes on x, y and signed_mode after capture have no effect.

Test Plan:
- WIDTH=6, DIGIT=1, unsigned; start with x=6'b100000, y=6'b011111 -> done 2 cycles after the accepting edge; gt=1, lt=0, eq=0.
- Same operands with signed_mode=1 (-32 vs 31) -> done after 2 cycles; lt=1, gt=0.
- x=y=6'd42 -> done after 7 cycles; eq=1. Then start with x=6'd1, y=6'd0 -> done after 7 cycles; gt=1. eq holds 1 through the second SCAN until the second done.
- WIDTH=6, DIGIT=4 (NCHUNK=2): x=6'b000010, y=6'b000011 -> lower chunk zero-padded; done after 3 cycles; lt=1. x=6'b110000, y=6'b010000 -> done after 2 cycles; gt=1.
- Assert start again in mid-SCAN with different x/y -> ignored; result reflects the originally captured operands.
- Raise rst asynchronously mid-SCAN -> busy/gt/lt/eq drop to 0 immediately, with no done pulse. Release rst, then start x=5, y=9 -> normal lt=1 completion.
